// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles, memory handshake stall, stall counter.
// Optional access timeout is enabled with `define PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [2:0]  id_rs1_addr,
  input  logic [2:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic [2:0]  ex_rdest_addr,
  input  logic        ex_flush,
  input  logic        mem_valid,
  input  logic        mem_ack,
  output logic        pc_wen,
  output logic        IFtoID_Wen,
  output logic        IDtoEX_Wen,
  output logic        EXtoMEM_Wen,
  output logic        MEMtoWB_Wen,
  output logic        if_bubble,
  output logic        id_bubble,
  output logic        mem_req,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {RUN, WAIT, DONE} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        hazard, timeout, adv;

  assign hazard = ex_valid & ex_load & id_valid &
                  ((id_rs1_used & (id_rs1_addr == ex_rdest_addr)) |
                   (id_rs2_used & (id_rs2_addr == ex_rdest_addr)));

  // DONE advances unconditionally: its access already completed.
  assign adv = (state == DONE) || (state == RUN && !mem_valid);

`ifdef PIPE_CTRL_TIMEOUT_EN
  logic [7:0] wcnt;

  assign timeout = (state == WAIT) && !mem_ack && (wcnt == 8'(TIMEOUT_CYCLES - 1));

  // Held at zero outside WAIT, so the first WAIT cycle sees 0.
  always_ff @(posedge clk) begin
    if (!resetn)              wcnt <= '0;
    else if (state != WAIT)   wcnt <= '0;
    else if (!mem_ack)        wcnt <= wcnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    pc_wen      = 1'b0;
    IFtoID_Wen  = 1'b0;
    IDtoEX_Wen  = 1'b0;
    EXtoMEM_Wen = 1'b0;
    MEMtoWB_Wen = 1'b0;
    if_bubble   = 1'b0;
    id_bubble   = 1'b0;
    mem_req     = 1'b0;
    mem_err     = 1'b0;
    if (resetn) begin
      if (adv) begin
        IDtoEX_Wen  = 1'b1;
        EXtoMEM_Wen = 1'b1;
        MEMtoWB_Wen = 1'b1;
        if (ex_flush) begin
          pc_wen     = 1'b1;
          IFtoID_Wen = 1'b1;
          if_bubble  = 1'b1;
          id_bubble  = 1'b1;
        end else if (hazard) begin
          id_bubble  = 1'b1;
        end else begin
          pc_wen     = 1'b1;
          IFtoID_Wen = 1'b1;
        end
      end
      mem_req = (state == WAIT);
      mem_err = timeout;
    end
  end

  assign stall_cnt = resetn ? cnt : 16'h0000;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN:     if (mem_valid) state <= WAIT;
        WAIT:    if (mem_ack || timeout) state <= DONE;
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
      if (!pc_wen && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

endmodule
